// File: rtl/alu_issue_8bit_pkg.sv
// rtl/alu_issue_8bit_pkg.sv - shared constants and FSM encoding for the issue block
package alu_issue_8bit_pkg;

    localparam int DATA_W    = 8;
    localparam int REG_IDX_W = 3;

    localparam logic [3:0] ALUOP_ADD = 4'h7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/regfile_8x8.sv
// rtl/regfile_8x8.sv - 8x8 register file, two async reads, one sync write, r0 fixed at zero
module regfile_8x8
    import alu_issue_8bit_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 we,
    input  logic [REG_IDX_W-1:0] waddr,
    input  logic [DATA_W-1:0]    wdata,
    input  logic [REG_IDX_W-1:0] raddr1,
    input  logic [REG_IDX_W-1:0] raddr2,
    output logic [DATA_W-1:0]    rdata1,
    output logic [DATA_W-1:0]    rdata2
);

    logic [DATA_W-1:0] regs [0:(1<<REG_IDX_W)-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < (1<<REG_IDX_W); i++) begin
                regs[i] <= '0;
            end
        end else if (we && (waddr != '0)) begin
            regs[waddr] <= wdata;
        end
    end

    // r0 is forced on the read side so it never depends on the storage entry
    assign rdata1 = (raddr1 == '0) ? '0 : regs[raddr1];
    assign rdata2 = (raddr2 == '0) ? '0 : regs[raddr2];

endmodule

// File: rtl/alu_issue_8bit.sv
// rtl/alu_issue_8bit.sv - single-issue front end feeding an external 8-bit ALU
module alu_issue_8bit #(
    parameter int DATA_W  = 8,
    parameter int REG_NUM = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic [3:0]                 req_op,
    input  logic [$clog2(REG_NUM)-1:0] req_rd,
    input  logic [$clog2(REG_NUM)-1:0] req_rs1,
    input  logic [$clog2(REG_NUM)-1:0] req_rs2,
    input  logic                       req_cin,
    input  logic                       req_imm_en,
    input  logic                       req_ld,
    input  logic [DATA_W-1:0]          req_imm,
    output logic [DATA_W-1:0]          alu_a,
    output logic [DATA_W-1:0]          alu_b,
    output logic                       alu_cin,
    output logic [3:0]                 alu_aluop,
    input  logic [DATA_W-1:0]          alu_y,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic [$clog2(REG_NUM)-1:0] res_rd,
    output logic [DATA_W-1:0]          res_data
);
    import alu_issue_8bit_pkg::*;

    localparam int IDX_W = $clog2(REG_NUM);

    state_t state, state_n;
    logic   accept, capture, wr_en;

    logic [3:0]        op_q;
    logic [IDX_W-1:0]  rd_q;
    logic              cin_q, ld_q;
    logic [DATA_W-1:0] imm_q, a_q, b_q, res_q;
    logic [DATA_W-1:0] rs1_data, rs2_data;

    regfile_8x8 u_rf (
        .clk    (clk),
        .rst    (rst),
        .we     (wr_en),
        .waddr  (rd_q),
        .wdata  (res_q),
        .raddr1 (req_rs1),
        .raddr2 (req_rs2),
        .rdata1 (rs1_data),
        .rdata2 (rs2_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n   = state;
        req_ready = 1'b0;
        res_valid = 1'b0;
        accept    = 1'b0;
        capture   = 1'b0;
        wr_en     = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    accept  = 1'b1;
                    state_n = EXEC;
                end
            end
            EXEC: begin
                capture = 1'b1;
                state_n = RESP;
            end
            RESP: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    wr_en   = 1'b1;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Operand and result registers hold their values between requests, so the
    // ALU inputs stay at the last latched operation outside EXEC.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q  <= '0;
            rd_q  <= '0;
            cin_q <= 1'b0;
            ld_q  <= 1'b0;
            imm_q <= '0;
            a_q   <= '0;
            b_q   <= '0;
            res_q <= '0;
        end else begin
            if (accept) begin
                op_q  <= req_op;
                rd_q  <= req_rd;
                cin_q <= req_cin;
                ld_q  <= req_ld;
                imm_q <= req_imm;
                a_q   <= rs1_data;
                b_q   <= req_imm_en ? req_imm : rs2_data;
            end
            if (capture) begin
                res_q <= ld_q ? imm_q : alu_y;
            end
        end
    end

    assign alu_a     = a_q;
    assign alu_b     = b_q;
    assign alu_aluop = op_q;
    assign alu_cin   = cin_q && (op_q == ALUOP_ADD);
    assign res_rd    = rd_q;
    assign res_data  = res_q;

endmodule

// File: doc/alu_issue_8bit.md
ALU_ISSUE_8BIT -- requirements
Module: alu_issue_8bit

Interface
REQ-001 Parameter DATA_W, default 8, SHALL set operand/result width; only 8 is supported.
REQ-002 Parameter REG_NUM, default 8, SHALL set the register count; the index width is log2(REG_NUM) = 3.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 req_valid  input  1  request present.
REQ-006 req_ready  output  1  block can accept a request.
REQ-007 req_op  input  4  ALU opcode, passed unchanged to alu_aluop.
REQ-008 req_rd / req_rs1 / req_rs2  input  3 each  destination and source register indices.
REQ-009 req_cin  input  1  carry-in request.
REQ-010 req_imm_en  input  1  operand B SHALL be req_imm instead of reg[rs2].
REQ-011 req_ld  input  1  load: result SHALL be req_imm, with the ALU bypassed.
REQ-012 req_imm  input  8  immediate.
REQ-013 alu_a / alu_b  output  8  operands to the downstream 8-bit ALU.
REQ-014 alu_cin  output  1  carry-in to the ALU.
REQ-015 alu_aluop  output  4  opcode to the ALU.
REQ-016 alu_y  input  8  combinational ALU result.
REQ-017 res_valid  output  1  result available.
REQ-018 res_ready  input  1  consumer accepts the result.
REQ-019 res_rd  output  3  destination index of the result.
REQ-020 res_data  output  8  result value.

Function
REQ-021 The FSM SHALL have three states: IDLE, EXEC, RESP.
REQ-022 IDLE: req_ready=1; on req_valid the block SHALL latch op, rd, cin, ld, imm, opA=reg[rs1], and opB=(imm_en ? imm : reg[rs2]), then go to EXEC.
REQ-023 EXEC: req_ready=0; the ALU outputs SHALL be driven from the latched fields; on the next edge the result register SHALL capture (ld ? imm : alu_y) and the FSM SHALL go to RESP.
REQ-024 RESP: res_valid=1; res_rd and res_data SHALL hold stable until the handshake; on res_valid&&res_ready the block SHALL write reg[rd]=res_data (unless rd==0) and go to IDLE.
REQ-025 Latency: for a request accepted at edge N, res_valid SHALL be 1 from cycle N+2.
REQ-026 Throughput: at most one request SHALL be in flight, so the minimum issue interval is 3 cycles.
REQ-027 reg[0] SHALL always read 0; writes to index 0 SHALL be discarded.
REQ-028 alu_cin SHALL equal the latched cin only when op==4'h7 (ADD); otherwise it SHALL be 0.
REQ-029 Outside EXEC, alu_a, alu_b, alu_cin and alu_aluop SHALL keep their last latched values (no glitching to X).
REQ-030 A request accepted in the cycle after a RESP handshake SHALL read the register values written by that handshake (write-before-read is guaranteed by the state order).
REQ-031 res_ready held low SHALL stall in RESP indefinitely with no register write.
REQ-032 req_valid asserted outside IDLE SHALL be ignored; the requester holds it.
REQ-033 Addition is 8-bit with wrap-around; the carry-out is not retained.

Reset
REQ-034 While rst=1 at a clock edge, the FSM SHALL go to IDLE, all registers SHALL be cleared to 0, and all latched fields SHALL be cleared to 0.
REQ-035 After reset: req_ready=1, res_valid=0, res_rd=0, res_data=0, alu_a=alu_b=0, alu_cin=0, alu_aluop=0.
REQ-036 Reset asserted in EXEC or RESP SHALL abort the operation with no register write; rst has priority over the handshake.

Structure
REQ-037 The shared package SHALL hold the FSM state encodings, the ALUOP_ADD=4'h7 constant, DATA_W and the register-index width.
REQ-038 The register file SHALL be a sub-module regfile_8x8 with two async read ports, one sync write port, synchronous clear, and r0 hardwired to 0.
REQ-039 The downstream ALU SHALL be outside this block; the bench SHALL connect it or a reference model.

Verification
REQ-040 Reset for 2 cycles -> req_ready=1, res_valid=0, all alu_* outputs = 0 on the first cycle after release.
REQ-041 ld r1=0x93, then ld r2=0xA7 -> res_data=0x93/res_rd=1 two cycles after accept; reg1=0x93 and reg2=0xA7 after the handshakes.
REQ-042 op=7, rd=3, rs1=1, rs2=2, cin=1 -> in EXEC alu_a=0x93, alu_b=0xA7, alu_cin=1; res_data=0x3B; op=6 with cin=1 -> alu_cin=0.
REQ-043 res_ready low for 5 cycles in RESP -> res_valid and res_data stable, req_ready=0, no register write until the handshake.
REQ-044 ld rd=0 imm=0x55, then an op reading rs1=0 -> alu_a=0x00.
REQ-045 rst pulsed during EXEC of an op targeting r3 -> IDLE next cycle, res_valid=0, reg3 reads 0.
